// File: rtl/pool2d_stream.sv
// Streaming KxK pooling engine: reduces every K accepted rows into one pooled row
// (max or average), with a registered output that holds under backpressure.
module pool2d_stream #(
  parameter int R      = 16,
  parameter int W      = 8,
  parameter int K      = 2,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic                   mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [R-1:0][W-1:0]    s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [R/K-1:0][W-1:0]  m_data
);

  localparam int N  = R / K;
  localparam int LK = $clog2(K);
  localparam int SW = W + 2 * LK;

  logic [LK-1:0]          row_cnt;
  logic                   mode_q;
  logic [N-1:0][W-1:0]    max_acc;
  logic [N-1:0][SW-1:0]   sum_acc;
  logic [N-1:0][W-1:0]    grp_max;
  logic [N-1:0][SW-1:0]   grp_sum;
  logic [N-1:0][W-1:0]    nxt_max;
  logic [N-1:0][SW-1:0]   nxt_sum;
  logic [N-1:0][W-1:0]    result;
  logic                   first_row;
  logic                   last_row;
  logic                   accept;

  function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  function automatic logic [SW-1:0] extend(input logic [W-1:0] a);
    logic s;
    s = (SIGNED != 0) && a[W-1];
    return {{(2 * LK){s}}, a};
  endfunction

  assign first_row = (row_cnt == '0);
  assign last_row  = (row_cnt == LK'(K - 1));
  assign s_ready   = rstn && !clear && !(last_row && m_valid && !m_ready);
  assign accept    = s_valid && s_ready;

  // Reduce this row's K-wide column groups, then fold into the window accumulators;
  // dropping the low 2*log2(K) sum bits is a floor division by K*K in both signednesses.
  always_comb begin
    grp_max = '0;
    grp_sum = '0;
    nxt_max = '0;
    nxt_sum = '0;
    result  = '0;
    for (int j = 0; j < N; j++) begin
      grp_max[j] = s_data[j*K];
      grp_sum[j] = extend(s_data[j*K]);
      for (int k = 1; k < K; k++) begin
        if (greater(s_data[j*K+k], grp_max[j])) grp_max[j] = s_data[j*K+k];
        grp_sum[j] = grp_sum[j] + extend(s_data[j*K+k]);
      end
      nxt_max[j] = (first_row || greater(grp_max[j], max_acc[j])) ? grp_max[j] : max_acc[j];
      nxt_sum[j] = first_row ? grp_sum[j] : sum_acc[j] + grp_sum[j];
      result[j]  = mode_q ? nxt_sum[j][2*LK +: W] : nxt_max[j];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_cnt <= '0;
      mode_q  <= 1'b0;
      max_acc <= '0;
      sum_acc <= '0;
    end else if (clear) begin
      row_cnt <= '0;
    end else if (accept) begin
      row_cnt <= last_row ? '0 : row_cnt + LK'(1);
      if (first_row) mode_q <= mode;
      max_acc <= nxt_max;
      sum_acc <= nxt_sum;
    end
  end

  // A completing row reloads the output even while the old one drains on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (accept && last_row) begin
      m_valid <= 1'b1;
      m_data  <= result;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
